// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) block memory arbiter with registered memory strobes.
// Contention policy: fixed D-cache priority by default; `define ARB_ROUND_ROBIN_EN for round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       dc_grants,
    output logic [15:0]       ic_grants
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t state, state_nxt;
    logic   ic_req, dc_req;
    logic   grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic   prio_d;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ic_req   = ic_read;
    assign dc_req   = dc_read | dc_write;
    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        ic_ready  = 1'b0;
        dc_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (dc_req && ic_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (prio_d) grant_d = 1'b1;
                    else        grant_i = 1'b1;
`else
                    grant_d = 1'b1;
`endif
                end else if (dc_req) begin
                    grant_d = 1'b1;
                end else if (ic_req) begin
                    grant_i = 1'b1;
                end
                if (grant_d)      state_nxt = GRANT_D;
                else if (grant_i) state_nxt = GRANT_I;
            end
            GRANT_I: begin
                if (mem_ready) begin
                    ic_ready  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            GRANT_D: begin
                if (mem_ready) begin
                    dc_ready  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory side is latched once at grant and held until completion, so a
    // requester dropping its request mid-transaction cannot disturb the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_read  <= dc_read & ~dc_write;
            mem_write <= dc_write;
            mem_addr  <= dc_addr;
            mem_wdata <= dc_wdata;
        end else if (grant_i) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= ic_addr;
            mem_wdata <= '0;
        end else if (ic_ready || dc_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_grants <= '0;
            dc_grants <= '0;
        end else begin
            if (ic_ready) ic_grants <= sat_inc(ic_grants);
            if (dc_ready) dc_grants <= sat_inc(dc_grants);
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // prio_d=1 means the D-cache wins the next contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          prio_d <= 1'b1;
        else if (grant_d) prio_d <= 1'b0;
        else if (grant_i) prio_d <= 1'b1;
    end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, block-address width on all address ports.
REQ-002 Parameter DATA_W, default 128, cache-block width on all data ports.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ic_read  input  1  I-cache block-read request, held until ic_ready.
REQ-006 ic_addr  input  ADDR_W  I-cache block address.
REQ-007 ic_rdata  output  DATA_W  read block to I-cache.
REQ-008 ic_ready  output  1  I-cache transaction complete, 1-cycle pulse.
REQ-009 dc_read  input  1  D-cache block-read request, held until dc_ready.
REQ-010 dc_write  input  1  D-cache block-write (writeback) request, held until dc_ready.
REQ-011 dc_addr  input  ADDR_W  D-cache block address.
REQ-012 dc_wdata  input  DATA_W  D-cache write block.
REQ-013 dc_rdata  output  DATA_W  read block to D-cache.
REQ-014 dc_ready  output  1  D-cache transaction complete, 1-cycle pulse.
REQ-015 mem_read  output  1  memory read strobe, registered.
REQ-016 mem_write  output  1  memory write strobe, registered.
REQ-017 mem_addr  output  ADDR_W  memory block address, registered.
REQ-018 mem_wdata  output  DATA_W  memory write block, registered.
REQ-019 mem_rdata  input  DATA_W  memory read block.
REQ-020 mem_ready  input  1  memory transaction complete.
REQ-021 dc_grants  output  16  count of completed D-cache transactions, saturating at 16'hFFFF.
REQ-022 ic_grants  output  16  count of completed I-cache transactions, saturating at 16'hFFFF.

Function
REQ-023 FSM states SHALL be IDLE, GRANT_I, GRANT_D, RELEASE; only IDLE samples requests.
REQ-024 IDLE: a single pending requester SHALL be granted; no request -> stay IDLE.
REQ-025 Both pending in IDLE: the winner SHALL follow REQ-041/REQ-042.
REQ-026 On IDLE->GRANT_x at edge N, mem_read/mem_write/mem_addr/mem_wdata SHALL be driven from requester x, visible from cycle N+1.
REQ-027 dc_read and dc_write both high SHALL be treated as a write (mem_write=1, mem_read=0).
REQ-028 mem_* outputs SHALL stay constant throughout GRANT_x, even if the requester deasserts; the transaction is not abortable.
REQ-029 In GRANT_x with mem_ready=1: x_ready=1 combinationally that cycle, x_rdata=mem_rdata, next state RELEASE.
REQ-030 x_ready SHALL be 0 in every other state/cycle; rdata outputs SHALL pass mem_rdata always.
REQ-031 RELEASE SHALL last exactly one cycle with mem_read=mem_write=0, ignore all requests, then go to IDLE.
  - Prevents a held strobe being seen as a second access.
REQ-032 Minimum spacing: mem_ready at cycle M -> strobes low at M+1 -> next strobe no earlier than M+3.
REQ-033 mem_ready outside GRANT_x SHALL be ignored.
REQ-034 The x_grants counter SHALL increment by 1 on the cycle after each x_ready pulse and hold at 16'hFFFF.

Reset
REQ-035 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-036 Under rst=1: mem_read=mem_write=0; mem_addr=0; mem_wdata=0; counters=0.
REQ-037 Under rst=1: ic_ready=dc_ready=0; round-robin pointer = D-cache first.
REQ-038 Reset asserted mid-GRANT SHALL abandon the transaction; no ready pulse, no counter update.
REQ-039 The first grant is possible at the first rising edge after rst deasserts.

Configuration
REQ-040 Macro ARB_ROUND_ROBIN_EN SHALL select the simultaneous-request policy.
REQ-041 ARB_ROUND_ROBIN_EN defined: on contention, the winner is the requester not granted last.
  - A 1-bit pointer updates on every grant.
REQ-042 ARB_ROUND_ROBIN_EN undefined: fixed priority, D-cache always wins contention; no pointer register.

Verification
REQ-043 Reset then ic_read=1, ic_addr=28'h10, mem_ready 3 cycles after mem_read rises -> ic_ready pulses once, mem_read low next cycle, ic_grants=1.
REQ-044 dc_write=1, dc_addr=28'h20, dc_wdata=128'hA5.. -> mem_write=1 with mem_addr=28'h20, mem_wdata matching until mem_ready, then one RELEASE cycle with strobes 0.
REQ-045 ic_read and dc_read asserted together and held, 4 transactions: RR build grants D,I,D,I; non-RR build grants D,D,D,D with ic_ready never asserted.
REQ-046 rst=1 pulse mid-GRANT_D -> mem_read=0 immediately, dc_ready never pulses, dc_grants=0.
REQ-047 dc_read deasserted one cycle after grant -> mem_read stays 1 until mem_ready, dc_ready still pulses, dc_grants +1.
